// File: rtl/ctrl_pkg.sv
// Shared opcodes, control-field encodings and the ID/EX control bundle for the
// main control decoder.
package ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [2:0] {
        ImmI    = 3'b000,
        ImmS    = 3'b001,
        ImmB    = 3'b010,
        ImmJ    = 3'b011,
        ImmU    = 3'b100,
        ImmNone = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10,
        ResImm = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        AluAdd    = 2'b00,
        AluBranch = 2'b01,
        AluRtype  = 2'b10,
        AluItype  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic        regwrite;
        result_src_e resultsrc;
        logic        memwrite;
        logic        alusrc;
        logic        alusrca_pc;
        imm_src_e    immsrc;
        alu_op_e     aluop;
        logic        branch;
        logic        jump;
        logic        jumpreg;
        logic        illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '{
        regwrite:   1'b0,
        resultsrc:  ResAlu,
        memwrite:   1'b0,
        alusrc:     1'b0,
        alusrca_pc: 1'b0,
        immsrc:     ImmNone,
        aluop:      AluAdd,
        branch:     1'b0,
        jump:       1'b0,
        jumpreg:    1'b0,
        illegal:    1'b0
    };

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decoder: RV32I opcode to control bundle plus the
// source-register usage flags needed by hazard detection.
module ctrl_opdecode
    import ctrl_pkg::*;
#(
    parameter bit EN_UPPER = 1'b1
) (
    input  logic [6:0]   op,
    output ctrl_bundle_t ctrl,
    output logic         uses_rs1,
    output logic         uses_rs2
);

    always_comb begin
        ctrl     = BUBBLE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (op)
            OpLoad: begin
                ctrl.regwrite  = 1'b1;
                ctrl.resultsrc = ResMem;
                ctrl.alusrc    = 1'b1;
                ctrl.immsrc    = ImmI;
                uses_rs1       = 1'b1;
            end
            OpStore: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.immsrc   = ImmS;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OpRtype: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = AluRtype;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OpItype: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.immsrc   = ImmI;
                ctrl.aluop    = AluItype;
                uses_rs1      = 1'b1;
            end
            OpBranch: begin
                ctrl.immsrc = ImmB;
                ctrl.aluop  = AluBranch;
                ctrl.branch = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OpJal: begin
                ctrl.regwrite  = 1'b1;
                ctrl.resultsrc = ResPc4;
                ctrl.immsrc    = ImmJ;
                ctrl.jump      = 1'b1;
            end
            OpJalr: begin
                ctrl.regwrite  = 1'b1;
                ctrl.resultsrc = ResPc4;
                ctrl.alusrc    = 1'b1;
                ctrl.immsrc    = ImmI;
                ctrl.jump      = 1'b1;
                ctrl.jumpreg   = 1'b1;
                uses_rs1       = 1'b1;
            end
            OpLui: begin
                if (EN_UPPER) begin
                    ctrl.regwrite  = 1'b1;
                    ctrl.resultsrc = ResImm;
                    ctrl.immsrc    = ImmU;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OpAuipc: begin
                if (EN_UPPER) begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.alusrca_pc = 1'b1;
                    ctrl.immsrc     = ImmU;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Main control decoder with ID/EX control register, load-use stall detection
// and saturating stall/flush event counters.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter bit          EN_UPPER = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [6:0]        id_op_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              ex_flush_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [ADDR_W-1:0] ex_rd_o,
    output logic              ex_regwrite_o,
    output logic [1:0]        ex_resultsrc_o,
    output logic              ex_memwrite_o,
    output logic              ex_alusrc_o,
    output logic              ex_alusrca_pc_o,
    output logic [2:0]        ex_immsrc_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_branch_o,
    output logic              ex_jump_o,
    output logic              ex_jumpreg_o,
    output logic              ex_illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    ctrl_bundle_t      dec_ctrl;
    logic              uses_rs1, uses_rs2;
    logic              hazard;

    ctrl_bundle_t      ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] rd_d, rd_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;

    ctrl_opdecode #(
        .EN_UPPER (EN_UPPER)
    ) u_opdecode (
        .op       (id_op_i),
        .ctrl     (dec_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // Only a load in EX produces its result too late for forwarding into ID.
    always_comb begin
        hazard = id_valid_i && valid_q && (ctrl_q.resultsrc == ResMem) && (rd_q != '0) &&
                 ((uses_rs1 && (id_rs1_i == rd_q)) || (uses_rs2 && (id_rs2_i == rd_q)));
        stall_o = hazard && !ex_flush_i;
    end

    always_comb begin
        ctrl_d  = BUBBLE;
        valid_d = 1'b0;
        rd_d    = '0;
        if (!ex_flush_i && !stall_o && id_valid_i) begin
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
            rd_d    = id_rd_i;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_flush_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q      <= BUBBLE;
            valid_q     <= 1'b0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid_o      = valid_q;
    assign ex_rd_o         = rd_q;
    assign ex_regwrite_o   = ctrl_q.regwrite;
    assign ex_resultsrc_o  = ctrl_q.resultsrc;
    assign ex_memwrite_o   = ctrl_q.memwrite;
    assign ex_alusrc_o     = ctrl_q.alusrc;
    assign ex_alusrca_pc_o = ctrl_q.alusrca_pc;
    assign ex_immsrc_o     = ctrl_q.immsrc;
    assign ex_aluop_o      = ctrl_q.aluop;
    assign ex_branch_o     = ctrl_q.branch;
    assign ex_jump_o       = ctrl_q.jump;
    assign ex_jumpreg_o    = ctrl_q.jumpreg;
    assign ex_illegal_o    = ctrl_q.illegal;
    assign stall_cnt_o     = stall_cnt_q;
    assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: a default instance and an EN_UPPER=0,
// CNT_W=4 instance driven by the same stimulus.
module tb_ctrl_decode_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_flush;

    logic        stall_a, valid_a, regw_a, memw_a, alusrc_a, alusrca_a, br_a, j_a, jr_a, ill_a;
    logic [4:0]  rd_a;
    logic [1:0]  res_a, aluop_a;
    logic [2:0]  imm_a;
    logic [15:0] scnt_a, fcnt_a;

    logic        stall_b, valid_b, regw_b, memw_b, alusrc_b, alusrca_b, br_b, j_b, jr_b, ill_b;
    logic [4:0]  rd_b;
    logic [1:0]  res_b, aluop_b;
    logic [2:0]  imm_b;
    logic [3:0]  scnt_b, fcnt_b;

    logic [14:0] bund_a, bund_b;
    assign bund_a = {regw_a, res_a, memw_a, alusrc_a, alusrca_a, imm_a, aluop_a, br_a, j_a, jr_a,
                     ill_a};
    assign bund_b = {regw_b, res_b, memw_b, alusrc_b, alusrca_b, imm_b, aluop_b, br_b, j_b, jr_b,
                     ill_b};

    always #5 clk = ~clk;

    ctrl_decode_pipe u_dut_a (
        .clk (clk), .rst_n (rst_n), .id_valid_i (id_valid), .id_op_i (id_op),
        .id_rs1_i (id_rs1), .id_rs2_i (id_rs2), .id_rd_i (id_rd), .ex_flush_i (ex_flush),
        .stall_o (stall_a), .ex_valid_o (valid_a), .ex_rd_o (rd_a), .ex_regwrite_o (regw_a),
        .ex_resultsrc_o (res_a), .ex_memwrite_o (memw_a), .ex_alusrc_o (alusrc_a),
        .ex_alusrca_pc_o (alusrca_a), .ex_immsrc_o (imm_a), .ex_aluop_o (aluop_a),
        .ex_branch_o (br_a), .ex_jump_o (j_a), .ex_jumpreg_o (jr_a), .ex_illegal_o (ill_a),
        .stall_cnt_o (scnt_a), .flush_cnt_o (fcnt_a)
    );

    ctrl_decode_pipe #(.ADDR_W (5), .EN_UPPER (1'b0), .CNT_W (4)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .id_valid_i (id_valid), .id_op_i (id_op),
        .id_rs1_i (id_rs1), .id_rs2_i (id_rs2), .id_rd_i (id_rd), .ex_flush_i (ex_flush),
        .stall_o (stall_b), .ex_valid_o (valid_b), .ex_rd_o (rd_b), .ex_regwrite_o (regw_b),
        .ex_resultsrc_o (res_b), .ex_memwrite_o (memw_b), .ex_alusrc_o (alusrc_b),
        .ex_alusrca_pc_o (alusrca_b), .ex_immsrc_o (imm_b), .ex_aluop_o (aluop_b),
        .ex_branch_o (br_b), .ex_jump_o (j_b), .ex_jumpreg_o (jr_b), .ex_illegal_o (ill_b),
        .stall_cnt_o (scnt_b), .flush_cnt_o (fcnt_b)
    );

    // Field order: regwrite, resultsrc, memwrite, alusrc, alusrca_pc, immsrc, aluop,
    // branch, jump, jumpreg, illegal.
    localparam logic [14:0] BubbleExp = 15'b0_00_0_0_0_111_00_0_0_0_0;
    localparam logic [14:0] IllExp    = 15'b0_00_0_0_0_111_00_0_0_0_1;

    typedef struct {
        logic [6:0]  op;
        logic [14:0] exp_a;
        logic [14:0] exp_b;
    } vec_t;

    vec_t vecs[10];
    int   total = 0;
    int   passed = 0;
    int   exp_scnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v;
        id_op    = op;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
    endtask

    initial begin
        vecs[0] = '{7'b0000011, 15'b1_01_0_1_0_000_00_0_0_0_0, 15'b1_01_0_1_0_000_00_0_0_0_0};
        vecs[1] = '{7'b0100011, 15'b0_00_1_1_0_001_00_0_0_0_0, 15'b0_00_1_1_0_001_00_0_0_0_0};
        vecs[2] = '{7'b0110011, 15'b1_00_0_0_0_111_10_0_0_0_0, 15'b1_00_0_0_0_111_10_0_0_0_0};
        vecs[3] = '{7'b0010011, 15'b1_00_0_1_0_000_11_0_0_0_0, 15'b1_00_0_1_0_000_11_0_0_0_0};
        vecs[4] = '{7'b1100011, 15'b0_00_0_0_0_010_01_1_0_0_0, 15'b0_00_0_0_0_010_01_1_0_0_0};
        vecs[5] = '{7'b1101111, 15'b1_10_0_0_0_011_00_0_1_0_0, 15'b1_10_0_0_0_011_00_0_1_0_0};
        vecs[6] = '{7'b1100111, 15'b1_10_0_1_0_000_00_0_1_1_0, 15'b1_10_0_1_0_000_00_0_1_1_0};
        vecs[7] = '{7'b0110111, 15'b1_11_0_0_0_100_00_0_0_0_0, IllExp};
        vecs[8] = '{7'b0010111, 15'b1_00_0_1_1_100_00_0_0_0_0, IllExp};
        vecs[9] = '{7'b1111111, IllExp, IllExp};

        rst_n    = 1'b0;
        ex_flush = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom_range(0, 1)), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom));
            ex_flush = 1'($urandom_range(0, 1));
            step();
        end

        // Reset arriving while a load-use stall is pending.
        ex_flush = 1'b0;
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        step();
        drive(1'b1, 7'b0110011, 5'd5, 5'd1, 5'd6);
        #1;
        chk("pre_reset_stall", 32'(stall_a), 32'd1);
        rst_n = 1'b0;
        step();
        chk("reset_drops_stall", 32'(stall_a), 32'd0);
        step();
        chk("reset_bundle", 32'(bund_a), 32'(BubbleExp));
        chk("reset_valid", 32'(valid_a), 32'd0);
        chk("reset_rd", 32'(rd_a), 32'd0);
        chk("reset_scnt", 32'(scnt_a), 32'd0);
        chk("reset_fcnt", 32'(fcnt_a), 32'd0);
        chk("reset_fcnt_b", 32'(fcnt_b), 32'd0);
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        step();

        // Decode sweep: rs fields are x0, so no hazard can arise.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, 5'd0, 5'd0, 5'(i + 1));
            #1;
            chk($sformatf("sweep%0d_stall", i), 32'(stall_a), 32'd0);
            step();
            chk($sformatf("sweep%0d_bundle", i), 32'(bund_a), 32'(vecs[i].exp_a));
            chk($sformatf("sweep%0d_bundle_noupper", i), 32'(bund_b), 32'(vecs[i].exp_b));
            chk($sformatf("sweep%0d_valid", i), 32'(valid_a), 32'd1);
            chk($sformatf("sweep%0d_rd", i), 32'(rd_a), 32'(i + 1));
        end

        // id_valid low loads a bubble.
        drive(1'b0, 7'b0000011, 5'd0, 5'd0, 5'd3);
        step();
        chk("idle_valid", 32'(valid_a), 32'd0);
        chk("idle_bundle", 32'(bund_a), 32'(BubbleExp));

        // Load-use: lw x5 ; add x6,x5,x1.
        exp_scnt = 0;
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        #1;
        chk("lu_lw_stall", 32'(stall_a), 32'd0);
        step();
        drive(1'b1, 7'b0110011, 5'd5, 5'd1, 5'd6);
        #1;
        chk("lu_stall", 32'(stall_a), 32'd1);
        step();
        exp_scnt++;
        chk("lu_bubble_valid", 32'(valid_a), 32'd0);
        chk("lu_bubble_bundle", 32'(bund_a), 32'(BubbleExp));
        chk("lu_scnt", 32'(scnt_a), 32'(exp_scnt));
        chk("lu_scnt_b", 32'(scnt_b), 32'(exp_scnt));
        chk("lu_stall_released", 32'(stall_a), 32'd0);
        step();
        chk("lu_add_valid", 32'(valid_a), 32'd1);
        chk("lu_add_rd", 32'(rd_a), 32'd6);
        chk("lu_add_bundle", 32'(bund_a), 32'(vecs[2].exp_a));
        chk("lu_scnt_hold", 32'(scnt_a), 32'(exp_scnt));

        // No false stall on x0 destination or on JAL.
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd0);
        step();
        drive(1'b1, 7'b0110011, 5'd0, 5'd0, 5'd1);
        #1;
        chk("x0_no_stall", 32'(stall_a), 32'd0);
        step();
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5);
        step();
        drive(1'b1, 7'b1101111, 5'd5, 5'd5, 5'd5);
        #1;
        chk("jal_no_stall", 32'(stall_a), 32'd0);
        step();

        // Store reading the load result through rs2 must stall.
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd9);
        step();
        drive(1'b1, 7'b0100011, 5'd1, 5'd9, 5'd0);
        #1;
        chk("sw_rs2_stall", 32'(stall_a), 32'd1);
        step();
        exp_scnt++;
        chk("sw_scnt", 32'(scnt_a), 32'(exp_scnt));
        step();
        chk("sw_enters", 32'(bund_a), 32'(vecs[1].exp_a));

        // Flush with a simultaneous load-use hazard.
        drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd7);
        step();
        drive(1'b1, 7'b0110011, 5'd7, 5'd2, 5'd8);
        ex_flush = 1'b1;
        #1;
        chk("flush_stall_suppressed", 32'(stall_a), 32'd0);
        step();
        ex_flush = 1'b0;
        chk("flush_valid", 32'(valid_a), 32'd0);
        chk("flush_bundle", 32'(bund_a), 32'(BubbleExp));
        chk("flush_fcnt", 32'(fcnt_a), 32'd1);
        chk("flush_scnt", 32'(scnt_a), 32'(exp_scnt));

        // Saturation of the 4-bit counter across 20 flush cycles.
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        ex_flush = 1'b1;
        for (int i = 0; i < 20; i++) step();
        ex_flush = 1'b0;
        chk("sat_fcnt_b", 32'(fcnt_b), 32'd15);
        chk("sat_fcnt_a", 32'(fcnt_a), 32'd21);
        step();
        chk("sat_fcnt_b_hold", 32'(fcnt_b), 32'd15);
        chk("sat_scnt_b", 32'(scnt_b), 32'(exp_scnt));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Second-generation main control decoder with an integrated ID/EX control pipeline register.
- Decodes the 7-bit RV32I opcode into a control bundle and registers it into the EX stage.
- Detects load-use hazards against the instruction in EX and raises a stall.
- Accepts flushes from EX branch/jump resolution and keeps saturating stall/flush event counters.
- Sits between the fetch/decode register and the ALU/datapath control inputs of the pipelined core.

Parameters:
ADDR_W, 5, register-address width for rs1/rs2/rd hazard comparison
EN_UPPER, 1, 1 = decode LUI (0110111) and AUIPC (0010111); 0 = treat both as illegal
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
id_valid_i  in  1  ID holds a real instruction
id_op_i  in  7  opcode of the ID instruction
id_rs1_i  in  ADDR_W  source register 1
id_rs2_i  in  ADDR_W  source register 2
id_rd_i  in  ADDR_W  destination register
ex_flush_i  in  1  EX redirect (taken branch or jump); kills ID and EX contents
stall_o  out  1  combinational; hold PC and IF/ID
ex_valid_o  out  1  EX slot holds a real instruction
ex_rd_o  out  ADDR_W  registered rd
ex_regwrite_o  out  1  register write enable
ex_resultsrc_o  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
ex_memwrite_o  out  1  store enable
ex_alusrc_o  out  1  ALU operand B is the immediate
ex_alusrca_pc_o  out  1  ALU operand A is the PC (AUIPC)
ex_immsrc_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U, 111 none
ex_aluop_o  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type ALU
ex_branch_o  out  1  conditional branch
ex_jump_o  out  1  JAL or JALR
ex_jumpreg_o  out  1  JALR (target taken from rs1 plus immediate)
ex_illegal_o  out  1  unrecognised opcode
stall_cnt_o  out  CNT_W  cycles in which a stall was asserted
flush_cnt_o  out  CNT_W  cycles in which a flush was accepted

Behaviour:
Decode is combinational on id_op_i. Fields are listed as RegWrite, ResultSrc, MemWrite, ALUsrc, ALUsrcA_PC, ImmSrc, ALUop, Branch, Jump, JumpReg.
- Load 0000011: 1,01,0,1,0,000,00,0,0,0
- Store 0100011: 0,00,1,1,0,001,00,0,0,0
- R-type 0110011: 1,00,0,0,0,111,10,0,0,0
- I-type ALU 0010011: 1,00,0,1,0,000,11,0,0,0
- Branch 1100011: 0,00,0,0,0,010,01,1,0,0
- JAL 1101111: 1,10,0,0,0,011,00,0,1,0
- JALR 1100111: 1,10,0,1,0,000,00,0,1,1 (JALR uses the I-immediate)
- LUI 0110111: 1,11,0,0,0,100,00,0,0,0
- AUIPC 0010111: 1,00,0,1,1,100,00,0,0,0
- Any other opcode, or LUI/AUIPC when EN_UPPER=0: bubble bundle with illegal=1.
- Bubble bundle: all fields 0, ImmSrc=111, illegal=0.

Register usage:
- uses_rs1 is set for load, store, R-type, I-type ALU, branch and JALR.
- uses_rs2 is set for store, R-type and branch.

Load-use hazard:
- hazard = id_valid_i & ex_valid_o & (ex_resultsrc_o==01) & (ex_rd_o!=0) & ((uses_rs1 & id_rs1_i==ex_rd_o) | (uses_rs2 & id_rs2_i==ex_rd_o)).
- stall_o = hazard & ~ex_flush_i.

ID/EX register update on each rising clk, in priority order:
1. rst_n=0: bubble, ex_valid_o=0, ex_rd_o=0, both counters 0. Reset mid-stall drops the stall on the next cycle.
2. ex_flush_i=1: load bubble, ex_valid_o=0. Flush wins over a simultaneous stall.
3. stall_o=1: load bubble, ex_valid_o=0. The ID instruction is re-presented by the upstream hold.
4. id_valid_i=0: load bubble.
5. Otherwise: load the decoded bundle and id_rd_i, ex_valid_o=1. An illegal opcode still enters EX with ex_illegal_o=1 and RegWrite/MemWrite=0.

Latency and counters:
- Decode-to-EX latency is 1 cycle. stall_o has 0-cycle latency and is never registered.
- A stall lasts exactly 1 cycle per load-use pair, because the bubble clears ex_valid_o.
- Counters increment when stall_o (respectively ex_flush_i) is 1 and not in reset. They saturate at all-ones and do not wrap.

Decomposition:
- Package ctrl_pkg holds opcode localparams, ImmSrc/ResultSrc/ALUop enums, the ctrl_bundle_t packed struct, and the BUBBLE constant.
- One sub-module, ctrl_opdecode: purely combinational, taking op and EN_UPPER and producing ctrl_bundle_t, uses_rs1 and uses_rs2.
- Hazard logic, the pipeline register and the counters live in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles after random traffic -> all ex_* outputs are the bubble values, ImmSrc=111, ex_valid_o=0, both counters 0.
- Decode sweep: each of the 9 opcodes with id_valid_i=1, no hazard -> the next cycle's EX bundle matches the table. With EN_UPPER=0, LUI -> ex_illegal_o=1 and ex_regwrite_o=0.
- Load-use: lw x5 then add x6,x5,x1 -> stall_o=1 for exactly one cycle and a bubble enters EX. The add enters EX the cycle after, and stall_cnt_o=1.
- No false stall: lw x0 then add x1,x0,x0 -> stall_o=0. lw x5 then jal x5 -> stall_o=0 (JAL uses no rs).
- Flush versus stall: a load-use hazard with ex_flush_i=1 in the same cycle -> stall_o=0, the next EX is a bubble, flush_cnt_o increments and stall_cnt_o does not.
- Saturation: CNT_W=4, 20 consecutive flush cycles -> flush_cnt_o holds at 15.
